// File: rtl/alu_frame_sequencer.sv
// Handshaked frame sequencer wrapping a combinational ALU: collects {opcode, A, B}, issues, holds response.
// Optional macro ALU_ACCUM_CHAIN_EN: opcode bit 7 reuses the previous result as operand A (2-beat frame).
module alu_frame_sequencer #(
   parameter int WIDTH          = 8,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             abort
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_GOT_OP = 3'd1;
   localparam logic [2:0] ST_GOT_A  = 3'd2;
   localparam logic [2:0] ST_ISSUE  = 3'd3;
   localparam logic [2:0] ST_RESP   = 3'd4;

   // A limit of zero disables the abort path entirely; the counter then never moves.
   localparam bit              TO_EN     = (TIMEOUT_CYCLES > 0);
   localparam int              TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [TO_W-1:0] TO_LAST   = TO_LAST_I[TO_W-1:0];

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_sel_q, alu_sel_d;
   logic [WIDTH-1:0] out_result_q, out_result_d;
   logic             out_carry_q, out_carry_d;
   logic             out_zero_q, out_zero_d;
   logic             out_valid_q, out_valid_d;
   logic             abort_q, abort_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             accepting;
   logic             beat;

   always_comb begin
      accepting = (state_q == ST_IDLE) || (state_q == ST_GOT_OP) || (state_q == ST_GOT_A);
      beat      = in_valid && accepting;
   end

   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_sel_d    = alu_sel_q;
      out_result_d = out_result_q;
      out_carry_d  = out_carry_q;
      out_zero_d   = out_zero_q;
      out_valid_d  = out_valid_q;
      abort_d      = 1'b0;
      to_cnt_d     = '0;

      case (state_q)
         ST_IDLE: begin
            if (beat) begin
               alu_sel_d = in_data[2:0];
               state_d   = ST_GOT_OP;
`ifdef ALU_ACCUM_CHAIN_EN
               // Chained opcode: operand A is the held result, so wait directly for B.
               if (in_data[7]) begin
                  alu_a_d = out_result_q;
                  state_d = ST_GOT_A;
               end
`endif
            end
         end

         ST_GOT_OP, ST_GOT_A: begin
            if (beat) begin
               if (state_q == ST_GOT_OP) begin
                  alu_a_d = in_data;
                  state_d = ST_GOT_A;
               end else begin
                  alu_b_d = in_data;
                  state_d = ST_ISSUE;
               end
            end else if (TO_EN) begin
               // A beat on the limit edge takes the branch above, so it always wins over abort.
               if (to_cnt_q == TO_LAST) begin
                  state_d = ST_IDLE;
                  abort_d = 1'b1;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
               end
            end
         end

         ST_ISSUE: begin
            out_result_d = alu_result;
            out_carry_d  = alu_carry;
            out_zero_d   = (alu_result == '0);
            out_valid_d  = 1'b1;
            state_d      = ST_RESP;
         end

         ST_RESP: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sel_q    <= '0;
         out_result_q <= '0;
         out_carry_q  <= 1'b0;
         out_zero_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         abort_q      <= 1'b0;
         to_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_sel_q    <= alu_sel_d;
         out_result_q <= out_result_d;
         out_carry_q  <= out_carry_d;
         out_zero_q   <= out_zero_d;
         out_valid_q  <= out_valid_d;
         abort_q      <= abort_d;
         to_cnt_q     <= to_cnt_d;
      end
   end

   assign in_ready   = accepting;
   assign busy       = (state_q != ST_IDLE);
   assign abort      = abort_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_sel    = alu_sel_q;
   assign out_result = out_result_q;
   assign out_carry  = out_carry_q;
   assign out_zero   = out_zero_q;
   assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Self-checking bench for alu_frame_sequencer: directed table, multi-cycle corner sequences, random frames.
module tb_alu_frame_sequencer;

   typedef struct {
      logic [7:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       c;
   } vec_t;

   typedef struct {
      logic [7:0] res;
      logic       c;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] alu_a, alu_b, alu_result, out_result;
   logic [2:0] alu_sel;
   logic       alu_carry, out_carry, out_zero, out_valid, out_ready, busy, abort;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   abort_cnt = 0;
   int   rdy_mode = 0;
   exp_t exp_q[$];
   vec_t tbl[9];

   always #5 clk = ~clk;

   alu_frame_sequencer #(.WIDTH(8), .TIMEOUT_CYCLES(4), .TO_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result), .alu_carry(alu_carry),
      .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .abort(abort)
   );

   // Stand-in combinational ALU driven from the DUT's registered operands.
   function automatic logic [8:0] alu_fn(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
      case (s)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {(a < b), 8'(a - b)};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         3'd5:    return {1'b0, ~a};
         3'd6:    return {a[7], a[6:0], 1'b0};
         default: return {a[0], 1'b0, a[7:1]};
      endcase
   endfunction

   always_comb {alu_carry, alu_result} = alu_fn(alu_sel, alu_a, alu_b);

   // Arithmetic reference for a whole frame.
   function automatic exp_t ref_model(input int sel, input int a, input int b);
      exp_t e;
      int   r;
      e.c = 1'b0;
      case (sel)
         0: begin r = a + b; e.c = (r > 255); end
         1: begin r = a - b; e.c = (r < 0); if (r < 0) r = r + 256; end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = 255 - a;
         6: begin r = a * 2; e.c = (r > 255); end
         default: begin r = a / 2; e.c = ((a % 2) == 1); end
      endcase
      e.res = 8'(r % 256);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [7:0] r, input logic c);
      exp_t e;
      e.res = r;
      e.c   = c;
      exp_q.push_back(e);
   endtask

   // Response scoreboard: a handshake happens at the posedge following a negedge with valid & ready.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp: got %0h required none", out_result);
         end else begin
            e = exp_q.pop_front();
            chk("resp_result", 32'(out_result), 32'(e.res));
            chk("resp_carry", 32'(out_carry), 32'(e.c));
            chk("resp_zero", 32'(out_zero), 32'(e.res == 8'h00));
         end
      end
      if (rst_n && abort) abort_cnt++;
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rdy_mode == 0)      out_ready = 1'b0;
         else if (rdy_mode == 1) out_ready = 1'b1;
         else                    out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_beat(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL beat_accept: in_ready %0b required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int base;
      int n_ab;
      exp_t e;
      logic [7:0] op, a, b;
      logic [2:0] s;

      tbl[0] = '{8'h00, 8'h7F, 8'h01, 8'h80, 1'b0};
      tbl[1] = '{8'h00, 8'hFF, 8'h01, 8'h00, 1'b1};
      tbl[2] = '{8'h02, 8'hF0, 8'h3C, 8'h30, 1'b0};
      tbl[3] = '{8'h04, 8'hAA, 8'hFF, 8'h55, 1'b0};
      tbl[4] = '{8'h01, 8'h05, 8'h07, 8'hFE, 1'b1};
      tbl[5] = '{8'h03, 8'h00, 8'h00, 8'h00, 1'b0};
      tbl[6] = '{8'h7A, 8'h0F, 8'h3C, 8'h0C, 1'b0};
      tbl[7] = '{8'h06, 8'h81, 8'h00, 8'h02, 1'b1};
      tbl[8] = '{8'h07, 8'h81, 8'h00, 8'h40, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      chk("rst_alu_sel", 32'(alu_sel), 32'd0);
      chk("rst_out_result", 32'(out_result), 32'd0);
      chk("rst_out_carry", 32'(out_carry), 32'd0);
      chk("rst_out_zero", 32'(out_zero), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed table, consumer always ready.
      rdy_mode = 1;
      for (int i = 0; i < 9; i++) begin
         push_exp(tbl[i].res, tbl[i].c);
         send_beat(tbl[i].op);
         send_beat(tbl[i].a);
         send_beat(tbl[i].b);
         chk("lat_issue_valid", 32'(out_valid), 32'd0);
         chk("issue_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
         chk("lat_resp_valid", 32'(out_valid), 32'd1);
         chk("alu_sel_reg", 32'(alu_sel), 32'(tbl[i].op[2:0]));
         chk("alu_a_reg", 32'(alu_a), 32'(tbl[i].a));
         chk("alu_b_reg", 32'(alu_b), 32'(tbl[i].b));
      end
      wait_drain();
      chk("operands_held", 32'(alu_a), 32'h81);

      // Held response with consumer stalled.
      rdy_mode = 0;
      idle(2);
      push_exp(8'h00, 1'b1);
      send_beat(8'h00); send_beat(8'hFF); send_beat(8'h01);
      idle(1);
      for (int k = 0; k < 5; k++) begin
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_result", 32'(out_result), 32'h00);
         chk("hold_carry", 32'(out_carry), 32'd1);
         chk("hold_zero", 32'(out_zero), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_busy", 32'(busy), 32'd1);
         idle(1);
      end
      rdy_mode = 1;
      wait_drain();
      idle(1);
      chk("after_drain_in_ready", 32'(in_ready), 32'd1);

      // Partial frame stalls until abort.
      base = abort_cnt;
      send_beat(8'h00);
      send_beat(8'h12);
      idle(3);
      chk("to_pre_abort", 32'(abort), 32'd0);
      chk("to_pre_busy", 32'(busy), 32'd1);
      idle(1);
      chk("to_abort", 32'(abort), 32'd1);
      chk("to_idle_busy", 32'(busy), 32'd0);
      chk("to_no_resp", 32'(out_valid), 32'd0);
      idle(1);
      chk("to_abort_pulse", 32'(abort), 32'd0);
      chk("to_abort_count", 32'(abort_cnt - base), 32'd1);
      push_exp(8'h05, 1'b0);
      send_beat(8'h01); send_beat(8'h09); send_beat(8'h04);
      wait_drain();

      // Beat on the limit edge wins.
      base = abort_cnt;
      push_exp(8'h30, 1'b0);
      send_beat(8'h00);
      idle(3);
      send_beat(8'h10);
      idle(3);
      send_beat(8'h20);
      wait_drain();
      chk("limit_beat_no_abort", 32'(abort_cnt - base), 32'd0);

      // Reset between A and B beats.
      send_beat(8'h00);
      send_beat(8'h34);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_alu_a", 32'(alu_a), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      push_exp(8'h80, 1'b0);
      send_beat(8'h00); send_beat(8'h7F); send_beat(8'h01);
      wait_drain();

      // Reset while a response is held.
      rdy_mode = 0;
      idle(2);
      send_beat(8'h00); send_beat(8'h0F); send_beat(8'h01);
      idle(1);
      chk("resprst_valid_before", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("resprst_valid", 32'(out_valid), 32'd0);
      chk("resprst_result", 32'(out_result), 32'd0);
      chk("resprst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      rdy_mode = 1;
      idle(2);

`ifdef ALU_ACCUM_CHAIN_EN
      push_exp(8'h08, 1'b0);
      send_beat(8'h00); send_beat(8'h05); send_beat(8'h03);
      wait_drain();
      push_exp(8'h0A, 1'b0);
      send_beat(8'h80); send_beat(8'h02);
      wait_drain();
      chk("chain_alu_a", 32'(alu_a), 32'h08);
`endif

      // Randomized frames, gaps, abandoned frames and consumer backpressure.
      rdy_mode = 2;
      base = abort_cnt;
      n_ab = 0;
      for (int i = 0; i < 80; i++) begin
         s  = 3'($urandom_range(0, 7));
         op = {1'($urandom), 4'($urandom), s};
`ifdef ALU_ACCUM_CHAIN_EN
         op[7] = 1'b0;
`endif
         a = 8'($urandom);
         b = 8'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            send_beat(op);
            if ($urandom_range(0, 1) == 1) send_beat(a);
            idle(5);
            n_ab++;
         end else begin
            e = ref_model(int'(s), int'(a), int'(b));
            push_exp(e.res, e.c);
            send_beat(op);
            idle($urandom_range(0, 3));
            send_beat(a);
            idle($urandom_range(0, 3));
            send_beat(b);
         end
      end
      wait_drain();
      chk("rand_abort_count", 32'(abort_cnt - base), 32'(n_ab));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
